pipe_stage_ctrl: RTL and testbench



---
 rtl/pipe_stage_ctrl_pkg.sv | 40 ++++
 rtl/pipe_stage_ctrl_load_use_detect.sv | 23 ++
 rtl/pipe_stage_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_stage_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: memory-handshake state
// codes and the bundle of stage-register controls.
package pipe_stage_ctrl_pkg;

    typedef logic [1:0] mem_state_t;

    localparam mem_state_t MS_IDLE = 2'd0;
    localparam mem_state_t MS_WAIT = 2'd1;
    localparam mem_state_t MS_ERR  = 2'd2;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_exe_en;
        logic exe_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_exe_flush;
        logic exe_mem_flush;
        logic mem_wb_bubble;
    } PipeCtrl;

    // Reset forces every stage register to load a bubble while holding still.
    localparam PipeCtrl CTRL_RESET = '{
        pc_en: 1'b0, if_id_en: 1'b0, id_exe_en: 1'b0, exe_mem_en: 1'b0, mem_wb_en: 1'b0,
        if_id_flush: 1'b1, id_exe_flush: 1'b1, exe_mem_flush: 1'b1, mem_wb_bubble: 1'b1
    };

    localparam PipeCtrl CTRL_RUN = '{
        pc_en: 1'b1, if_id_en: 1'b1, id_exe_en: 1'b1, exe_mem_en: 1'b1, mem_wb_en: 1'b1,
        if_id_flush: 1'b0, id_exe_flush: 1'b0, exe_mem_flush: 1'b0, mem_wb_bubble: 1'b0
    };

    // Everything up to MEM holds; WB keeps draining but receives a bubble.
    localparam PipeCtrl CTRL_FREEZE = '{
        pc_en: 1'b0, if_id_en: 1'b0, id_exe_en: 1'b0, exe_mem_en: 1'b0, mem_wb_en: 1'b1,
        if_id_flush: 1'b0, id_exe_flush: 1'b0, exe_mem_flush: 1'b0, mem_wb_bubble: 1'b1
    };

endpackage

// File: rtl/pipe_stage_ctrl_load_use_detect.sv
// Combinational load-use hazard detector: a load in EXE whose destination is
// read by the instruction currently in ID.
module load_use_detect
    import pipe_stage_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_write_reg,
    output logic       hazard
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_write_reg == id_rs);
    assign rt_match = id_uses_rt && (ex_write_reg == id_rt);

    // $zero is never a real dependency.
    assign hazard = ex_mem_read && (ex_write_reg != 5'd0) && (rs_match || rt_match);

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory-wait freeze with
// timeout, branch and jump flushes, and load-use bubbles.
module pipe_stage_ctrl
    import pipe_stage_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_write_reg,
    input  logic             id_jump,
    input  logic             mem_branch_taken,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_exe_en,
    output logic             exe_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_exe_flush,
    output logic             exe_mem_flush,
    output logic             mem_wb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    mem_state_t        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic    lu_hazard;
    logic    mem_stall;
    logic    frozen;
    PipeCtrl ctrl;

    load_use_detect u_load_use_detect (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_write_reg (ex_write_reg),
        .hazard       (lu_hazard)
    );

    // The first stalled cycle seen from IDLE counts as wait cycle 1.
    assign wait_inc = (state_q == MS_WAIT) ? wait_q + WAIT_W'(1) : WAIT_W'(1);

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        mem_stall = 1'b0;
        case (state_q)
            MS_IDLE, MS_WAIT: begin
                mem_stall = !dmem_ready && (mem_req || (state_q == MS_WAIT));
                if (mem_stall) begin
                    wait_d = wait_inc;
                    if (wait_inc == WAIT_W'(MEM_TIMEOUT)) begin
                        state_d   = MS_ERR;
                        timeout_d = 1'b1;
                    end else begin
                        state_d = MS_WAIT;
                    end
                end else begin
                    state_d = MS_IDLE;
                    wait_d  = '0;
                end
            end
            MS_ERR:  state_d = MS_ERR;
            default: begin
                state_d = MS_IDLE;
                wait_d  = '0;
            end
        endcase
    end

    assign frozen = mem_stall || (state_q == MS_ERR);

    always_comb begin
        ctrl = CTRL_RUN;
        if (!rst_n) begin
            ctrl = CTRL_RESET;
        end else if (frozen) begin
            ctrl = CTRL_FREEZE;
        end else if (mem_branch_taken) begin
            ctrl.if_id_flush   = 1'b1;
            ctrl.id_exe_flush  = 1'b1;
            ctrl.exe_mem_flush = 1'b1;
        end else if (lu_hazard) begin
            // Jump in ID is re-seen next cycle, so its flush waits until then.
            ctrl.pc_en        = 1'b0;
            ctrl.if_id_en     = 1'b0;
            ctrl.id_exe_flush = 1'b1;
        end else if (id_jump) begin
            ctrl.if_id_flush = 1'b1;
        end
    end

    assign stall_cnt_d = (!ctrl.pc_en && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1)
                                                             : stall_cnt_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= MS_IDLE;
            wait_q      <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign dmem_req      = rst_n && (state_q != MS_ERR) && mem_req;
    assign pc_en         = ctrl.pc_en;
    assign if_id_en      = ctrl.if_id_en;
    assign id_exe_en     = ctrl.id_exe_en;
    assign exe_mem_en    = ctrl.exe_mem_en;
    assign mem_wb_en     = ctrl.mem_wb_en;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_exe_flush  = ctrl.id_exe_flush;
    assign exe_mem_flush = ctrl.exe_mem_flush;
    assign mem_wb_bubble = ctrl.mem_wb_bubble;
    assign mem_timeout   = timeout_q;
    assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Bench for pipe_stage_ctrl: directed scenarios plus a randomized run checked
// against a cycle-level behavioural model of the stall/flush rules.
module tb_pipe_stage_ctrl;

    localparam int MEM_TIMEOUT = 16;

    // Output vector order: {dmem_req, pc_en, if_id_en, id_exe_en, exe_mem_en,
    // mem_wb_en, if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_bubble, mem_timeout}
    localparam logic [10:0] V_RESET    = 11'b0_00000_111_1_0;
    localparam logic [10:0] V_NORM     = 11'b0_11111_000_0_0;
    localparam logic [10:0] V_NORM_REQ = 11'b1_11111_000_0_0;
    localparam logic [10:0] V_LU       = 11'b0_00111_010_0_0;
    localparam logic [10:0] V_FRZ_REQ  = 11'b1_00001_000_1_0;
    localparam logic [10:0] V_BRANCH   = 11'b0_11111_111_0_0;
    localparam logic [10:0] V_JUMP     = 11'b0_11111_100_0_0;
    localparam logic [10:0] V_ERR      = 11'b0_00001_000_1_1;

    logic       clock;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_write_reg;
    logic       id_uses_rt, ex_mem_read, id_jump, mem_branch_taken, mem_req, dmem_ready;

    logic        dmem_req, pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en;
    logic        if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_bubble, mem_timeout;
    logic [15:0] stall_cnt;

    logic        s_dmem_req, s_pc_en, s_if_id_en, s_id_exe_en, s_exe_mem_en, s_mem_wb_en;
    logic        s_if_id_flush, s_id_exe_flush, s_exe_mem_flush, s_mem_wb_bubble, s_mem_timeout;
    logic [3:0]  s_stall_cnt;

    logic [10:0] obs, obs4;
    assign obs  = {dmem_req, pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
                   if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_bubble, mem_timeout};
    assign obs4 = {s_dmem_req, s_pc_en, s_if_id_en, s_id_exe_en, s_exe_mem_en, s_mem_wb_en,
                   s_if_id_flush, s_id_exe_flush, s_exe_mem_flush, s_mem_wb_bubble, s_mem_timeout};

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit m_err;
    int m_wait;
    int m_stall;

    pipe_stage_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(16)) dut (
        .clock(clock), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg), .id_jump(id_jump),
        .mem_branch_taken(mem_branch_taken), .mem_req(mem_req), .dmem_ready(dmem_ready),
        .dmem_req(dmem_req), .pc_en(pc_en), .if_id_en(if_id_en), .id_exe_en(id_exe_en),
        .exe_mem_en(exe_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
        .id_exe_flush(id_exe_flush), .exe_mem_flush(exe_mem_flush),
        .mem_wb_bubble(mem_wb_bubble), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
    );

    pipe_stage_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(4)) dut_small (
        .clock(clock), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg), .id_jump(id_jump),
        .mem_branch_taken(mem_branch_taken), .mem_req(mem_req), .dmem_ready(dmem_ready),
        .dmem_req(s_dmem_req), .pc_en(s_pc_en), .if_id_en(s_if_id_en), .id_exe_en(s_id_exe_en),
        .exe_mem_en(s_exe_mem_en), .mem_wb_en(s_mem_wb_en), .if_id_flush(s_if_id_flush),
        .id_exe_flush(s_id_exe_flush), .exe_mem_flush(s_exe_mem_flush),
        .mem_wb_bubble(s_mem_wb_bubble), .mem_timeout(s_mem_timeout), .stall_cnt(s_stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    function automatic bit model_mem_stall();
        return !m_err && !dmem_ready && (m_wait > 0 || mem_req);
    endfunction

    function automatic logic [10:0] model_ctrl();
        bit lu;
        bit dq;
        if (!rst_n) return V_RESET;
        if (m_err) return V_ERR;
        dq = mem_req;
        if (model_mem_stall()) return {dq, 10'b00001_000_1_0};
        lu = ex_mem_read && (ex_write_reg != 0) &&
             ((ex_write_reg == id_rs) || (id_uses_rt && (ex_write_reg == id_rt)));
        if (mem_branch_taken) return {dq, 10'b11111_111_0_0};
        if (lu)               return {dq, 10'b00111_010_0_0};
        if (id_jump)          return {dq, 10'b11111_100_0_0};
        return {dq, 10'b11111_000_0_0};
    endfunction

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_mem_read = 0; ex_write_reg = 0;
        id_jump = 0; mem_branch_taken = 0; mem_req = 0; dmem_ready = 0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        m_err = 0; m_wait = 0; m_stall = 0;
        @(posedge clock); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        mem_req = 1; ex_mem_read = 1; ex_write_reg = 3; id_rs = 3;
        @(negedge clock);
        checks++;
        if (obs !== V_RESET) begin
            errors++; $display("FAIL reset_outputs: got %b expected %b", obs, V_RESET);
        end
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
        end
        @(posedge clock); #1;
        rst_n = 1'b1;
        clear_inputs();
        @(negedge clock);
        checks++;
        if (obs !== V_NORM) begin
            errors++; $display("FAIL post_reset_normal: got %b expected %b", obs, V_NORM);
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        ex_mem_read = 1; ex_write_reg = 8; id_rs = 8;
        @(negedge clock);
        checks++;
        if (obs !== V_LU) begin
            errors++; $display("FAIL load_use_rs: got %b expected %b", obs, V_LU);
        end
        @(posedge clock); #1;
        clear_inputs();
        @(negedge clock);
        checks++;
        if (obs !== V_NORM) begin
            errors++; $display("FAIL load_use_single_bubble: got %b expected %b", obs, V_NORM);
        end
        checks++;
        if (stall_cnt !== 16'd1) begin
            errors++; $display("FAIL load_use_stall_cnt: got %0d expected 1", stall_cnt);
        end
        @(posedge clock); #1;
        ex_mem_read = 1; ex_write_reg = 0; id_rs = 0;
        @(negedge clock);
        checks++;
        if (obs !== V_NORM) begin
            errors++; $display("FAIL load_use_zero_reg: got %b expected %b", obs, V_NORM);
        end
        @(posedge clock); #1;
        ex_write_reg = 5; id_rs = 3; id_rt = 5; id_uses_rt = 1;
        @(negedge clock);
        checks++;
        if (obs !== V_LU) begin
            errors++; $display("FAIL load_use_rt: got %b expected %b", obs, V_LU);
        end
        @(posedge clock); #1;
        id_uses_rt = 0;
        @(negedge clock);
        checks++;
        if (obs !== V_NORM) begin
            errors++; $display("FAIL load_use_rt_unused: got %b expected %b", obs, V_NORM);
        end
        @(posedge clock); #1;
        checks++;
        if (stall_cnt !== 16'd2) begin
            errors++; $display("FAIL load_use_stall_cnt2: got %0d expected 2", stall_cnt);
        end
    endtask

    task automatic test_mem_wait();
        apply_reset();
        mem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (obs !== V_FRZ_REQ) begin
                errors++; $display("FAIL mem_wait_freeze[%0d]: got %b expected %b", i, obs, V_FRZ_REQ);
            end
            @(posedge clock); #1;
        end
        dmem_ready = 1;
        @(negedge clock);
        checks++;
        if (obs !== V_NORM_REQ) begin
            errors++; $display("FAIL mem_wait_release: got %b expected %b", obs, V_NORM_REQ);
        end
        @(posedge clock); #1;
        mem_req = 0; dmem_ready = 0;
        @(negedge clock);
        checks++;
        if (obs !== V_NORM) begin
            errors++; $display("FAIL mem_wait_back_idle: got %b expected %b", obs, V_NORM);
        end
        checks++;
        if (stall_cnt !== 16'd3) begin
            errors++; $display("FAIL mem_wait_stall_cnt: got %0d expected 3", stall_cnt);
        end
        // Reset in the middle of a wait
        @(posedge clock); #1;
        mem_req = 1;
        @(posedge clock); #1;
        @(negedge clock);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== V_RESET || stall_cnt !== 16'd0) begin
            errors++; $display("FAIL mem_wait_async_reset: got %b cnt %0d expected %b cnt 0",
                               obs, stall_cnt, V_RESET);
        end
        @(posedge clock); #1;
        rst_n = 1'b1;
        mem_req = 0;
        @(negedge clock);
        checks++;
        if (obs !== V_NORM) begin
            errors++; $display("FAIL mem_wait_reset_idle: got %b expected %b", obs, V_NORM);
        end
    endtask

    task automatic test_branch_priority();
        apply_reset();
        mem_branch_taken = 1; id_jump = 1; ex_mem_read = 1; ex_write_reg = 9; id_rs = 9;
        @(negedge clock);
        checks++;
        if (obs !== V_BRANCH) begin
            errors++; $display("FAIL branch_priority: got %b expected %b", obs, V_BRANCH);
        end
        @(posedge clock); #1;
        clear_inputs();
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++; $display("FAIL branch_stall_cnt: got %0d expected 0", stall_cnt);
        end
    endtask

    task automatic test_jump_during_load_use();
        apply_reset();
        id_jump = 1; ex_mem_read = 1; ex_write_reg = 4; id_rt = 4; id_uses_rt = 1;
        @(negedge clock);
        checks++;
        if (obs !== V_LU) begin
            errors++; $display("FAIL jump_suppressed: got %b expected %b", obs, V_LU);
        end
        @(posedge clock); #1;
        ex_mem_read = 0; ex_write_reg = 0;
        @(negedge clock);
        checks++;
        if (obs !== V_JUMP) begin
            errors++; $display("FAIL jump_after_stall: got %b expected %b", obs, V_JUMP);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        mem_req = 1; dmem_ready = 0;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            @(negedge clock);
            checks++;
            if (obs !== V_FRZ_REQ) begin
                errors++; $display("FAIL timeout_wait[%0d]: got %b expected %b", i, obs, V_FRZ_REQ);
            end
            @(posedge clock); #1;
        end
        @(negedge clock);
        checks++;
        if (obs !== V_ERR || stall_cnt !== 16'd16) begin
            errors++; $display("FAIL timeout_err: got %b cnt %0d expected %b cnt 16",
                               obs, stall_cnt, V_ERR);
        end
        #1;
        dmem_ready = 1; mem_branch_taken = 1;
        @(posedge clock); #1;
        @(negedge clock);
        checks++;
        if (obs !== V_ERR || stall_cnt !== 16'd17) begin
            errors++; $display("FAIL timeout_sticky: got %b cnt %0d expected %b cnt 17",
                               obs, stall_cnt, V_ERR);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== V_RESET || stall_cnt !== 16'd0) begin
            errors++; $display("FAIL timeout_reset: got %b cnt %0d expected %b cnt 0",
                               obs, stall_cnt, V_RESET);
        end
        @(posedge clock); #1;
        rst_n = 1'b1;
        clear_inputs();
        @(negedge clock);
        checks++;
        if (obs !== V_NORM) begin
            errors++; $display("FAIL timeout_cleared: got %b expected %b", obs, V_NORM);
        end
    endtask

    task automatic test_stall_saturation();
        apply_reset();
        ex_mem_read = 1; ex_write_reg = 2; id_rs = 2;
        repeat (14) @(posedge clock);
        #1;
        checks++;
        if (s_stall_cnt !== 4'd14) begin
            errors++; $display("FAIL sat_below: got %0d expected 14", s_stall_cnt);
        end
        repeat (6) @(posedge clock);
        #1;
        checks++;
        if (s_stall_cnt !== 4'd15 || stall_cnt !== 16'd20) begin
            errors++; $display("FAIL sat_hold: got %0d/%0d expected 15/20", s_stall_cnt, stall_cnt);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        bit frozen;
        bit st;
        logic [10:0] exp_v;
        int rdy_pct;
        int sat;
        apply_reset();
        frozen = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (!frozen) begin
                id_rs            = 5'($urandom_range(0, 3));
                id_rt            = 5'($urandom_range(0, 3));
                ex_write_reg     = 5'($urandom_range(0, 3));
                id_uses_rt       = 1'($urandom_range(0, 1));
                ex_mem_read      = ($urandom_range(0, 2) == 0);
                id_jump          = ($urandom_range(0, 3) == 0);
                mem_branch_taken = ($urandom_range(0, 5) == 0);
                mem_req          = ($urandom_range(0, 3) == 0);
            end
            rdy_pct = (cyc < 250) ? 70 : 8;
            dmem_ready = ($urandom_range(0, 99) < rdy_pct);
            @(negedge clock);
            exp_v = model_ctrl();
            st = model_mem_stall();
            checks++;
            if (obs !== exp_v || obs4 !== exp_v) begin
                errors++; $display("FAIL random_ctrl[%0d]: got %b/%b expected %b", cyc, obs, obs4, exp_v);
            end
            sat = (m_stall > 65535) ? 65535 : m_stall;
            checks++;
            if (stall_cnt !== 16'(sat)) begin
                errors++; $display("FAIL random_stall_cnt[%0d]: got %0d expected %0d", cyc, stall_cnt, sat);
            end
            sat = (m_stall > 15) ? 15 : m_stall;
            checks++;
            if (s_stall_cnt !== 4'(sat)) begin
                errors++; $display("FAIL random_stall_cnt4[%0d]: got %0d expected %0d", cyc, s_stall_cnt, sat);
            end
            frozen = m_err || st;
            @(posedge clock);
            if (!m_err) begin
                if (st) begin
                    m_wait++;
                    if (m_wait >= MEM_TIMEOUT) m_err = 1;
                end else begin
                    m_wait = 0;
                end
            end
            if (exp_v[9] == 1'b0) m_stall++;
            #1;
            if (m_err && $urandom_range(0, 9) == 0) begin
                apply_reset();
                frozen = 0;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        m_err = 0; m_wait = 0; m_stall = 0;
        @(posedge clock); #1;
        test_reset();
        test_load_use();
        test_mem_wait();
        test_branch_priority();
        test_jump_during_load_use();
        test_timeout();
        test_stall_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
